// File: rtl/tm_spi_pkg.sv
// Shared constants and FSM state type for the tape-memory SPI responder.
package tm_spi_pkg;

  localparam logic [7:0] SPI_RCMD = 8'h03;
  localparam logic [7:0] SPI_WCMD = 8'h02;

  typedef enum logic [2:0] {
    StCmd,
    StAddr,
    StRead,
    StWrite,
    StIgnore
  } spi_state_e;

endpackage

// File: rtl/tm_spi_shift_in.sv
// MSB-first deserializer for the SPI responder.
// word presents the value including the current bit, so the FSM can act on the same clk as the
// completing rise. clr beats rise.
module tm_spi_shift_in
  import tm_spi_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         rise,
  input  logic         din,
  output logic [W-1:0] word,
  output logic [4:0]   cnt,
  output logic         full
);

  logic [W-1:0] data_q;
  logic [4:0]   cnt_q;

  assign word = {data_q[W-2:0], din};
  assign cnt  = cnt_q;
  assign full = rise & (cnt_q == 5'(W - 1));

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (rise) begin
      data_q <= word;
      cnt_q  <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/tm_spi_resp.sv
// SPI responder (target) for the tape-memory link: command byte, word address, then 16-bit
// words MSB-first. Optional write support is enabled by defining TM_SPI_RESP_WRITE_EN.
// Assumes AW <= DW (the address is taken from the low bits of the data deserializer).
module tm_spi_resp
  import tm_spi_pkg::*;
#(
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 16,
  parameter logic [7:0]  RCMD = SPI_RCMD,
  parameter logic [7:0]  WCMD = SPI_WCMD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_cs,
  input  logic          spi_sck,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          busy_o,
  output logic          cmd_err_o
);

`ifdef TM_SPI_RESP_WRITE_EN
  localparam bit WrEn = 1'b1;
`else
  localparam bit WrEn = 1'b0;
`endif

  localparam int unsigned DBW = $clog2(DW);

  spi_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          sck_q, armed_q, wr_q, wr_d, we_q, we_d, err_q, err_d;
  logic          rise, clr, full;
  logic [DW-1:0] word;
  logic [4:0]    cnt;
  logic [DBW-1:0] bit_idx;

  // armed_q blocks a frame that was cut by rst from resuming until cs has been seen low.
  assign rise = spi_cs & spi_sck & ~sck_q & armed_q;

  tm_spi_shift_in #(
    .W(DW)
  ) u_shift_in (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .rise (rise),
    .din  (spi_mosi),
    .word (word),
    .cnt  (cnt),
    .full (full)
  );

  assign bit_idx     = DBW'(DW - 1) - cnt[DBW-1:0];
  assign spi_miso    = (spi_cs && state_q == StRead) ? mem_rdata_i[bit_idx] : 1'b0;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = WrEn & we_q;
  assign mem_wdata_o = WrEn ? wdata_q : '0;
  assign cmd_err_o   = err_q;
  assign busy_o      = spi_cs & ((state_q != StCmd) | (cnt != 5'd0));

  // Frame decode: next state, address, write strobe and error pulse.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    if (!spi_cs) begin
      state_d = StCmd;
      clr     = 1'b1;
    end else begin
      // Address advances the clk after a write strobe.
      if (we_q) addr_d = addr_q + AW'(1);
      unique case (state_q)
        StCmd: begin
          if (rise && cnt == 5'd7) begin
            clr = 1'b1;
            if (word[7:0] == RCMD) begin
              state_d = StAddr;
              wr_d    = 1'b0;
            end else if (WrEn && word[7:0] == WCMD) begin
              state_d = StAddr;
              wr_d    = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = StIgnore;
            end
          end
        end
        StAddr: begin
          if (rise && cnt == 5'(AW - 1)) begin
            clr     = 1'b1;
            addr_d  = word[AW-1:0];
            state_d = wr_q ? StWrite : StRead;
          end
        end
        StRead: begin
          if (full) begin
            clr    = 1'b1;
            addr_d = addr_q + AW'(1);
          end
        end
        StWrite: begin
          if (full) begin
            clr     = 1'b1;
            wdata_d = word;
            we_d    = 1'b1;
          end
        end
        StIgnore: clr = 1'b1;
        default: begin
          state_d = StCmd;
          clr     = 1'b1;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StCmd;
      addr_q  <= '0;
      wdata_q <= '0;
      sck_q   <= 1'b0;
      armed_q <= 1'b0;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sck_q   <= spi_sck;
      armed_q <= armed_q | ~spi_cs;
      wr_q    <= wr_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tm_spi_resp.sv
// Directed bench for tm_spi_resp: acts as SPI initiator and as the word memory.
module tb_tm_spi_resp;

  logic        clk = 1'b0;
  logic        rst, spi_cs, spi_sck, spi_mosi, spi_miso;
  logic [15:0] mem_addr_o, mem_rdata_i, mem_wdata_o;
  logic        mem_we_o, busy_o, cmd_err_o;

  logic [15:0] mem [0:65535];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  logic [15:0] we_addr_q[$];
  logic [15:0] we_data_q[$];

  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o];

  tm_spi_resp u_dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs      (spi_cs),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .busy_o      (busy_o),
    .cmd_err_o   (cmd_err_o)
  );

  // Record error pulses and write strobes.
  always @(negedge clk) begin
    if (cmd_err_o) err_cnt++;
    if (mem_we_o) begin
      we_addr_q.push_back(mem_addr_o);
      we_data_q.push_back(mem_wdata_o);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bit per 3 clks: sck low 1 clk, high 2 clk; miso sampled as sck rises.
  task automatic xfer(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); spi_sck = 1'b0; spi_mosi = tx[i];
      @(negedge clk); rx = {rx[30:0], spi_miso}; spi_sck = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic cs_begin();
    @(negedge clk); spi_cs = 1'b1;
  endtask

  task automatic cs_end();
    @(negedge clk); spi_sck = 1'b0; spi_cs = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] cmd, input logic [15:0] addr);
    logic [31:0] dummy;
    cs_begin();
    xfer({24'h0, cmd}, 8, dummy);
    xfer({16'h0, addr}, 16, dummy);
  endtask

  initial begin
    logic [31:0] rx;
    int e0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0010] = 16'hBEEF;
    mem[16'hFFFF] = 16'h1234;
    mem[16'h0000] = 16'h5678;
    mem[16'h0002] = 16'h2A5C;
    mem[16'h0003] = 16'hFFFF;
    mem[16'h0005] = 16'h8001;
    rst = 1'b1; spi_cs = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_addr", mem_addr_o, 16'h0);
    check_eq("rst_miso", spi_miso, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_err", cmd_err_o, 1'b0);
    check_eq("rst_we", mem_we_o, 1'b0);
    check_eq("rst_wdata", mem_wdata_o, 16'h0);

    // 1: single word read
    start_frame(8'h03, 16'h0010);
    check_eq("t1_addr", mem_addr_o, 16'h0010);
    check_eq("t1_busy", busy_o, 1'b1);
    xfer(32'h0, 16, rx);
    check_eq("t1_data", rx, 32'hBEEF);
    check_eq("t1_addr_inc", mem_addr_o, 16'h0011);
    cs_end();
    @(negedge clk);
    check_eq("t1_idle", busy_o, 1'b0);

    // 2: stream across the address wrap
    start_frame(8'h03, 16'hFFFF);
    xfer(32'h0, 16, rx);
    check_eq("t2_w0", rx, 32'h1234);
    check_eq("t2_wrap", mem_addr_o, 16'h0000);
    xfer(32'h0, 16, rx);
    check_eq("t2_w1", rx, 32'h5678);
    check_eq("t2_addr", mem_addr_o, 16'h0001);
    cs_end();

    // 3: unsupported command, then a short cs gap and a valid read
    e0 = err_cnt;
    cs_begin();
    xfer(32'hA5, 8, rx);
    xfer(32'hFFFF_FFFF, 32, rx);
    check_eq("t3_miso_a", rx, 32'h0);
    xfer(32'hFF, 8, rx);
    check_eq("t3_miso_b", rx, 32'h0);
    check_eq("t3_err", err_cnt - e0, 1);
    check_eq("t3_busy", busy_o, 1'b1);
    cs_end();
    start_frame(8'h03, 16'h0002);
    xfer(32'h0, 16, rx);
    check_eq("t3_data", rx, 32'h2A5C);
    cs_end();

    // 4: partial word dropped, next frame starts clean
    start_frame(8'h03, 16'h0003);
    xfer(32'h0, 7, rx);
    check_eq("t4_part", rx, 32'h7F);
    cs_end();
    start_frame(8'h03, 16'h0005);
    xfer(32'h0, 16, rx);
    check_eq("t4_data", rx, 32'h8001);
    cs_end();

    // 5: write command
    e0 = err_cnt;
    start_frame(8'h02, 16'h0100);
`ifdef TM_SPI_RESP_WRITE_EN
    xfer(32'hCAFE, 16, rx);
    xfer(32'h0001, 16, rx);
    cs_end();
    repeat (2) @(negedge clk);
    check_eq("t5_err", err_cnt - e0, 0);
    check_eq("t5_we_n", we_addr_q.size(), 2);
    if (we_addr_q.size() >= 2) begin
      check_eq("t5_a0", we_addr_q[0], 16'h0100);
      check_eq("t5_d0", we_data_q[0], 16'hCAFE);
      check_eq("t5_a1", we_addr_q[1], 16'h0101);
      check_eq("t5_d1", we_data_q[1], 16'h0001);
    end
`else
    xfer(32'hCAFE_0001, 32, rx);
    check_eq("t5_miso", rx, 32'h0);
    cs_end();
    repeat (2) @(negedge clk);
    check_eq("t5_err", err_cnt - e0, 1);
    check_eq("t5_we_n", we_addr_q.size(), 0);
`endif

    // 6: reset in the middle of a read
    start_frame(8'h03, 16'h0010);
    xfer(32'h0, 5, rx);
    check_eq("t6_part", rx, 32'h17);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("t6_addr", mem_addr_o, 16'h0);
    check_eq("t6_miso", spi_miso, 1'b0);
    check_eq("t6_busy", busy_o, 1'b0);
    check_eq("t6_err", cmd_err_o, 1'b0);
    check_eq("t6_we", mem_we_o, 1'b0);
    xfer(32'hFFFF, 16, rx);
    check_eq("t6_dead_miso", rx, 32'h0);
    check_eq("t6_dead_addr", mem_addr_o, 16'h0);
    check_eq("t6_dead_busy", busy_o, 1'b0);
    cs_end();
    start_frame(8'h03, 16'h0010);
    xfer(32'h0, 16, rx);
    check_eq("t6_resume", rx, 32'hBEEF);
    cs_end();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
